// File: rtl/brq_n_if.sv
// ----------------------------------------------------------------------------
// brq_n_if - request/issue bundle for the brq_n bus request queue.
//   master : requester/bus side (drives send_in, dest_in, req, free, pull)
//   slave  : queue side (drives ack, valid, send_out, dest_out, count, full)
// Signals:
//   send_in  [NUM_SRC*ID_W]   sender id per source, source s at [s*ID_W +: ID_W]
//   dest_in  [NUM_SRC*DST_W]  dest index per source, same packing
//   req      [NUM_SRC]        request per source, held until acked
//   ack      [NUM_SRC]        one-hot accept, combinational
//   free     [NUM_DEST]       destination d can accept a transfer
//   pull     1                bus takes an entry this cycle if valid
//   valid    1                an issuable entry exists and pull=1
//   send_out [ID_W]           sender of issued entry (0 when !valid)
//   dest_out [DST_W]          dest of issued entry (0 when !valid)
//   count    [clog2(DEPTH+1)] registered occupancy
//   full     1                count == DEPTH
// ----------------------------------------------------------------------------
interface brq_n_if #(
  parameter int NUM_SRC  = 4,
  parameter int NUM_DEST = 5,
  parameter int DEPTH    = 4,
  parameter int ID_W     = 4,
  parameter int DST_W    = 3
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [NUM_SRC*ID_W-1:0]  send_in;
  logic [NUM_SRC*DST_W-1:0] dest_in;
  logic [NUM_SRC-1:0]       req;
  logic [NUM_SRC-1:0]       ack;
  logic [NUM_DEST-1:0]      free;
  logic                     pull;
  logic                     valid;
  logic [ID_W-1:0]          send_out;
  logic [DST_W-1:0]         dest_out;
  logic [CNT_W-1:0]         count;
  logic                     full;

  modport master (
    output send_in, dest_in, req, free, pull,
    input  ack, valid, send_out, dest_out, count, full
  );

  modport slave (
    input  send_in, dest_in, req, free, pull,
    output ack, valid, send_out, dest_out, count, full
  );
endinterface

// File: rtl/brq_n.sv
// ----------------------------------------------------------------------------
// brq_n - parametrised bus request queue.
// Accepts one {sender,dest} request per cycle from NUM_SRC requesters into a
// DEPTH-entry collapsing queue (slot 0 = oldest) and issues the oldest entry
// whose destination is free whenever the bus pulls. Issue is therefore
// out-of-order across destinations but in-order per destination.
// Ports:
//   clk  - clock, all state on rising edge
//   clr  - asynchronous active-high reset
//   bus  - brq_n_if.slave request/issue bundle
// Configuration macro:
//   BRQ_RR_ARB_EN - defined: round-robin write arbitration with a pointer
//                   that moves to winner+1 on acked edges.
//                   undefined: fixed priority, highest source index wins.
// ----------------------------------------------------------------------------
module brq_n #(
  parameter int NUM_SRC  = 4,
  parameter int NUM_DEST = 5,
  parameter int DEPTH    = 4,
  parameter int ID_W     = 4,
  parameter int DST_W    = 3
) (
  input  logic   clk,
  input  logic   clr,
  brq_n_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  // Queue storage; slots [0, r_count) are valid, so the valid bits are implied
  // by the occupancy rather than stored.
  logic [ID_W-1:0]  r_snd [DEPTH];
  logic [DST_W-1:0] r_dst [DEPTH];
  logic [CNT_W-1:0] r_count;

  logic [DEPTH-1:0] w_dfree;
  logic [DEPTH-1:0] w_ready;
  logic             w_valid;
  logic [IDX_W-1:0] w_iss_idx;
  logic             w_full;
  logic             w_any;
  logic [SRC_W-1:0] w_win;
  logic             w_write;
  logic [ID_W-1:0]  w_wr_snd;
  logic [DST_W-1:0] w_wr_dst;
  logic [CNT_W-1:0] w_tail;

  // Readiness per slot. Out-of-range destinations match no free bit and are
  // therefore never issued.
  always_comb begin
    w_dfree = '0;
    w_ready = '0;
    for (int e = 0; e < DEPTH; e++) begin
      for (int d = 0; d < NUM_DEST; d++) begin
        if (r_dst[e] == DST_W'(d)) w_dfree[e] = bus.free[d];
      end
      w_ready[e] = (CNT_W'(e) < r_count) & w_dfree[e] & bus.pull;
    end
  end

  // Lowest ready slot wins: descending scan so the last hit is the oldest.
  always_comb begin
    w_iss_idx = '0;
    for (int e = DEPTH - 1; e >= 0; e--) begin
      if (w_ready[e]) w_iss_idx = IDX_W'(e);
    end
  end

  assign w_valid = |w_ready;
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_any   = |bus.req;

`ifdef BRQ_RR_ARB_EN
  logic [SRC_W-1:0] r_ptr;

  // Search starts at the pointer and wraps; first requester found wins.
  always_comb begin
    logic       found;
    logic [SRC_W-1:0] cand;
    found = 1'b0;
    cand  = '0;
    w_win = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = SRC_W'((int'(r_ptr) + k) % NUM_SRC);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        w_win = cand;
      end
    end
  end
`else
  always_comb begin
    w_win = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (bus.req[s]) w_win = SRC_W'(s);
    end
  end
`endif

  always_comb begin
    w_wr_snd = '0;
    w_wr_dst = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (w_win == SRC_W'(s)) begin
        w_wr_snd = bus.send_in[s*ID_W +: ID_W];
        w_wr_dst = bus.dest_in[s*DST_W +: DST_W];
      end
    end
  end

  // A full queue only accepts when an entry leaves on the same edge.
  assign w_write = !clr && w_any && (!w_full || w_valid);
  // Tail position after the collapse of an issued slot.
  assign w_tail  = r_count - CNT_W'(w_valid);

  assign bus.ack      = w_write ? (NUM_SRC'(1) << w_win) : '0;
  assign bus.valid    = w_valid && !clr;
  assign bus.send_out = bus.valid ? r_snd[w_iss_idx] : '0;
  assign bus.dest_out = bus.valid ? r_dst[w_iss_idx] : '0;
  assign bus.count    = r_count;
  assign bus.full     = w_full;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int e = 0; e < DEPTH; e++) begin
        r_snd[e] <= '0;
        r_dst[e] <= '0;
      end
      r_count <= '0;
`ifdef BRQ_RR_ARB_EN
      r_ptr   <= '0;
`endif
    end else begin
      // Collapse: everything younger than the issued slot moves down one.
      if (w_valid) begin
        for (int e = 0; e < DEPTH - 1; e++) begin
          if (IDX_W'(e) >= w_iss_idx) begin
            r_snd[e] <= r_snd[e+1];
            r_dst[e] <= r_dst[e+1];
          end
        end
      end
      // Tail write after the collapse; later assignment overrides the shift.
      if (w_write) begin
        r_snd[IDX_W'(w_tail)] <= w_wr_snd;
        r_dst[IDX_W'(w_tail)] <= w_wr_dst;
      end
      r_count <= r_count + CNT_W'(w_write) - CNT_W'(w_valid);
`ifdef BRQ_RR_ARB_EN
      if (w_write) begin
        r_ptr <= (int'(w_win) == NUM_SRC - 1) ? '0 : w_win + SRC_W'(1);
      end
`endif
    end
  end
endmodule

// File: tb/tb_brq_n.sv
module tb_brq_n;
  localparam int NUM_SRC  = 4;
  localparam int NUM_DEST = 5;
  localparam int DEPTH    = 4;
  localparam int ID_W     = 4;
  localparam int DST_W    = 3;

  typedef struct packed {
    logic [ID_W-1:0]  snd;
    logic [DST_W-1:0] dst;
  } ent_t;

  logic clk = 1'b0;
  logic clr;

  brq_n_if #(.NUM_SRC(NUM_SRC), .NUM_DEST(NUM_DEST), .DEPTH(DEPTH),
             .ID_W(ID_W), .DST_W(DST_W)) bus ();

  brq_n #(.NUM_SRC(NUM_SRC), .NUM_DEST(NUM_DEST), .DEPTH(DEPTH),
          .ID_W(ID_W), .DST_W(DST_W)) u_dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_err = 0;
  ent_t sb_q[$];
  int   sb_ptr = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic set_src(input int s, input int id, input int dst);
    bus.send_in[s*ID_W +: ID_W]   = ID_W'(id);
    bus.dest_in[s*DST_W +: DST_W] = DST_W'(dst);
  endtask

  // One clock: predict from the scoreboard, compare at negedge, update at posedge.
  task automatic step(input string tag);
    int   ri;
    int   win;
    int   c;
    bit   can;
    logic [NUM_SRC-1:0] eack;
    ent_t exp_e;
    ent_t new_e;
    @(negedge clk);
    for (int s = 0; s < NUM_SRC; s++) begin
      if (bus.req[s]) begin
        assert (int'(bus.dest_in[s*DST_W +: DST_W]) < NUM_DEST)
          else $fatal(1, "FAIL illegal dest driven on source %0d", s);
      end
    end
    ri = -1;
    if (bus.pull) begin
      for (int i = 0; i < sb_q.size(); i++) begin
        if (ri < 0 && bus.free[sb_q[i].dst]) ri = i;
      end
    end
    win = -1;
`ifdef BRQ_RR_ARB_EN
    for (int k = 0; k < NUM_SRC; k++) begin
      c = (sb_ptr + k) % NUM_SRC;
      if (win < 0 && bus.req[c]) win = c;
    end
`else
    c = 0;
    for (int s = 0; s < NUM_SRC; s++) if (bus.req[s]) win = s;
`endif
    can  = (sb_q.size() < DEPTH) || (ri >= 0);
    eack = (win >= 0 && can) ? NUM_SRC'(1 << win) : '0;
    exp_e = (ri >= 0) ? sb_q[ri] : '0;
    check_val({tag, ".valid"}, bus.valid, (ri >= 0));
    check_val({tag, ".send_out"}, bus.send_out, exp_e.snd);
    check_val({tag, ".dest_out"}, bus.dest_out, exp_e.dst);
    check_val({tag, ".ack"}, bus.ack, eack);
    check_val({tag, ".count"}, bus.count, sb_q.size());
    check_val({tag, ".full"}, bus.full, (sb_q.size() == DEPTH));
    @(posedge clk);
    if (ri >= 0) sb_q.delete(ri);
    if (eack != 0) begin
      new_e.snd = bus.send_in[win*ID_W +: ID_W];
      new_e.dst = bus.dest_in[win*DST_W +: DST_W];
      sb_q.push_back(new_e);
      sb_ptr = (win + 1) % NUM_SRC;
    end
    #1;
  endtask

  task automatic pulse_clr();
    bus.req  = '0;
    bus.pull = 1'b0;
    clr = 1'b1;
    #2;
    clr = 1'b0;
    sb_q.delete();
    sb_ptr = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int n, input int base_id, input int base_dst, input int dst_inc);
    bus.pull = 1'b0;
    bus.req  = 4'b0001;
    for (int i = 0; i < n; i++) begin
      set_src(0, base_id + i, base_dst + i * dst_inc);
      step("load");
    end
    bus.req = '0;
  endtask

  initial begin
    clr = 1'b1;
    bus.req = '0; bus.pull = 1'b0; bus.free = '0;
    bus.send_in = '0; bus.dest_in = '0;
    #12;
    bus.req = 4'b1111; bus.pull = 1'b1; bus.free = '1;
    #1;
    check_val("rst.count", bus.count, 0);
    check_val("rst.full", bus.full, 0);
    check_val("rst.valid", bus.valid, 0);
    check_val("rst.ack", bus.ack, 0);
    bus.req = '0; bus.pull = 1'b0;
    @(negedge clk) clr = 1'b0;
    @(posedge clk); #1;

    // Fill with pull low: four acks, then full blocks a fifth.
    bus.free = '1;
    load(4, 5, 0, 1);
    bus.req = 4'b0001;
    set_src(0, 12, 4);
    step("fill5");
    check_val("fill.full", bus.full, 1);
    pulse_clr();

    // Out-of-order issue across destinations.
    bus.free = '0;
    load(1, 1, 2, 0);
    load(1, 2, 0, 0);
    bus.pull = 1'b1; bus.free = 5'b00001;
    step("ooo1");
    bus.free = 5'b00100;
    step("ooo2");
    step("ooo3");
    pulse_clr();

    // Full + issue + write on the same edge; new entry lands at the tail.
    load(4, 1, 0, 1);
    bus.pull = 1'b1; bus.free = '1;
    bus.req = 4'b1000;
    set_src(3, 9, 4);
    step("fiw");
    check_val("fiw.count", bus.count, 4);
    bus.req = '0; bus.free = 5'b10000;
    step("fiw_tail");
    bus.free = '1;
    for (int i = 0; i < 4; i++) step("fiw_drain");
    pulse_clr();

    // Arbitration with all sources requesting.
    for (int s = 0; s < NUM_SRC; s++) set_src(s, 8 + s, s);
    bus.req = 4'b1111; bus.pull = 1'b1; bus.free = '1;
    for (int i = 0; i < 4; i++) step("arb");
    bus.req = '0;
    for (int i = 0; i < 2; i++) step("arb_drain");
    pulse_clr();

    // Same destination: arrival order, one per cycle.
    load(3, 3, 4, 0);
    bus.pull = 1'b1; bus.free = 5'b10000;
    for (int i = 0; i < 4; i++) step("order");
    pulse_clr();

    // Asynchronous clear mid-cycle with three entries held.
    load(3, 6, 1, 1);
    bus.req = 4'b0001; bus.pull = 1'b1; bus.free = '1;
    #2;
    clr = 1'b1;
    #1;
    check_val("aclr.count", bus.count, 0);
    check_val("aclr.valid", bus.valid, 0);
    check_val("aclr.ack", bus.ack, 0);
    check_val("aclr.full", bus.full, 0);
    bus.req = '0; bus.pull = 1'b0;
    sb_q.delete();
    sb_ptr = 0;
    @(negedge clk) clr = 1'b0;
    @(posedge clk); #1;

    // Random traffic against the scoreboard.
    for (int i = 0; i < 400; i++) begin
      bus.req  = NUM_SRC'($urandom_range(0, 15));
      bus.free = NUM_DEST'($urandom_range(0, 31));
      bus.pull = ($urandom_range(0, 3) != 0);
      for (int s = 0; s < NUM_SRC; s++)
        set_src(s, $urandom_range(0, 15), $urandom_range(0, NUM_DEST - 1));
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
